arm_pipelined_flags_unit: RTL and testbench

Producer side of the conditional-execution interface. The block derives the NZCV status flags from Execute-stage ALU operands and result, and holds them in the architected flags register. It presents them to the condition checker as NZ/CV pairs. Updates are gated per group by the instruction's flag-write request, the condition checker's execute verdict, and pipeline stall/flush.

---
 rtl/arm_pipelined_flags_unit_pkg.sv | 46 ++++
 rtl/arm_pipelined_flag_gen.sv | 65 ++++++
 rtl/arm_pipelined_flags_unit.sv | 95 +++++++++
 tb/tb_arm_pipelined_flags_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipelined_flags_unit_pkg.sv
// Shared definitions for the conditional-execution interface.
// Holds the ALU operation encoding, the flag-group and flag-bit positions,
// and the condition-code enum used by this block and by the condition checker.
package arm_pipelined_flags_unit_pkg;

   localparam int unsigned ALU_CTRL_W = 2;
   localparam int unsigned FLAG_GRP_W = 2;
   localparam int unsigned COND_W     = 4;

   // Bit index into i_FlagWrite for each flag group
   localparam int unsigned FLAG_NZ = 1;
   localparam int unsigned FLAG_CV = 0;

   // Bit positions inside the NZ and CV pairs
   localparam int unsigned FLAG_N_BIT = 1;
   localparam int unsigned FLAG_Z_BIT = 0;
   localparam int unsigned FLAG_C_BIT = 1;
   localparam int unsigned FLAG_V_BIT = 0;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_e;

   typedef enum logic [COND_W-1:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

endpackage

// File: rtl/arm_pipelined_flag_gen.sv
// Pure combinational N/Z/C/V generator for the Execute-stage ALU.
// Ports:
//   src_a, src_b    ALU operands (src_b after the shifter)
//   alu_result      ALU result
//   alu_control     operation (ADD/SUB/AND/ORR)
//   shifter_carry   shifter carry-out, C for logical ops
//   v_prev          current architected V, kept by logical ops
//   flag_n_c .. flag_v_c   generated flags
module arm_pipelined_flag_gen
   import arm_pipelined_flags_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]      src_a,
   input  logic [WIDTH-1:0]      src_b,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic [ALU_CTRL_W-1:0] alu_control,
   input  logic                  shifter_carry,
   input  logic                  v_prev,
   output logic                  flag_n_c,
   output logic                  flag_z_c,
   output logic                  flag_c_c,
   output logic                  flag_v_c
);

   alu_ctrl_e op;
   logic      a_msb;
   logic      b_eff_msb;
   logic      r_msb;

   assign op        = alu_ctrl_e'(alu_control);
   assign a_msb     = src_a[WIDTH-1];
   assign r_msb     = alu_result[WIDTH-1];
   assign b_eff_msb = (op == ALU_SUB) ? ~src_b[WIDTH-1] : src_b[WIDTH-1];

   assign flag_n_c = r_msb;
   assign flag_z_c = (alu_result == '0);

   // Carry-out expressed as magnitude compares, so no wide sum is needed:
   // a+b overflows WIDTH bits iff a > ~b; a+~b+1 carries iff a >= b.
   always_comb begin
      flag_c_c = shifter_carry;
      flag_v_c = v_prev;
      unique case (op)
         ALU_ADD: begin
            flag_c_c = (src_a > ~src_b);
            flag_v_c = (a_msb == b_eff_msb) & (r_msb != a_msb);
         end
         ALU_SUB: begin
            flag_c_c = (src_a >= src_b);
            flag_v_c = (a_msb == b_eff_msb) & (r_msb != a_msb);
         end
         ALU_AND,
         ALU_ORR: begin
            flag_c_c = shifter_carry;
            flag_v_c = v_prev;
         end
         default: begin
            flag_c_c = shifter_carry;
            flag_v_c = v_prev;
         end
      endcase
   end

endmodule

// File: rtl/arm_pipelined_flags_unit.sv
// Architected NZCV flags register with per-group gated update.
// Ports:
//   i_CLK, i_RST                       clock, synchronous active-high reset
//   i_SrcA, i_SrcB, i_ALUResult        Execute-stage ALU operands and result
//   i_ALUControl, i_ShifterCarry       operation and shifter carry-out
//   i_FlagWrite                        [1] update NZ, [0] update CV
//   i_CondEx, i_Stall_E, i_Flush_E     update qualifiers
//   o_Flags_NZ, o_Flags_CV             registered flags
//   o_FlagsNext_NZ, o_FlagsNext_CV     combinational bypass of the next value
module arm_pipelined_flags_unit
   import arm_pipelined_flags_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [WIDTH-1:0]      i_SrcA,
   input  logic [WIDTH-1:0]      i_SrcB,
   input  logic [WIDTH-1:0]      i_ALUResult,
   input  logic [ALU_CTRL_W-1:0] i_ALUControl,
   input  logic                  i_ShifterCarry,
   input  logic [FLAG_GRP_W-1:0] i_FlagWrite,
   input  logic                  i_CondEx,
   input  logic                  i_Stall_E,
   input  logic                  i_Flush_E,
   output logic [FLAG_GRP_W-1:0] o_Flags_NZ,
   output logic [FLAG_GRP_W-1:0] o_Flags_CV,
   output logic [FLAG_GRP_W-1:0] o_FlagsNext_NZ,
   output logic [FLAG_GRP_W-1:0] o_FlagsNext_CV
);

   logic [FLAG_GRP_W-1:0] nz_q;
   logic [FLAG_GRP_W-1:0] cv_q;
   logic [FLAG_GRP_W-1:0] nz_next;
   logic [FLAG_GRP_W-1:0] cv_next;
   logic                  gen_n;
   logic                  gen_z;
   logic                  gen_c;
   logic                  gen_v;
   logic                  upd_ok;
   logic                  upd_nz;
   logic                  upd_cv;

   arm_pipelined_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .src_a         (i_SrcA),
      .src_b         (i_SrcB),
      .alu_result    (i_ALUResult),
      .alu_control   (i_ALUControl),
      .shifter_carry (i_ShifterCarry),
      .v_prev        (cv_q[FLAG_V_BIT]),
      .flag_n_c      (gen_n),
      .flag_z_c      (gen_z),
      .flag_c_c      (gen_c),
      .flag_v_c      (gen_v)
   );

   assign upd_ok = i_CondEx & ~i_Stall_E & ~i_Flush_E;
   assign upd_nz = i_FlagWrite[FLAG_NZ] & upd_ok;
   assign upd_cv = i_FlagWrite[FLAG_CV] & upd_ok;

   // Next-value mux; during reset the bypass mirrors the held register value
   always_comb begin
      nz_next = nz_q;
      cv_next = cv_q;
      if (!i_RST) begin
         if (upd_nz) begin
            nz_next[FLAG_N_BIT] = gen_n;
            nz_next[FLAG_Z_BIT] = gen_z;
         end
         if (upd_cv) begin
            cv_next[FLAG_C_BIT] = gen_c;
            cv_next[FLAG_V_BIT] = gen_v;
         end
      end
   end

   // Flags register; reset wins over any update on the same edge
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         nz_q <= '0;
         cv_q <= '0;
      end else begin
         nz_q <= nz_next;
         cv_q <= cv_next;
      end
   end

   assign o_Flags_NZ     = nz_q;
   assign o_Flags_CV     = cv_q;
   assign o_FlagsNext_NZ = nz_next;
   assign o_FlagsNext_CV = cv_next;

endmodule

// File: tb/tb_arm_pipelined_flags_unit.sv
module tb_arm_pipelined_flags_unit;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] alu_result;
   logic [1:0]       alu_control;
   logic             shifter_carry;
   logic [1:0]       flag_write;
   logic             cond_ex;
   logic             stall_e;
   logic             flush_e;
   logic [1:0]       flags_nz;
   logic [1:0]       flags_cv;
   logic [1:0]       flags_next_nz;
   logic [1:0]       flags_next_cv;

   int errors = 0;
   int checks = 0;

   arm_pipelined_flags_unit #(
      .WIDTH (WIDTH)
   ) dut (
      .i_CLK          (clk),
      .i_RST          (rst),
      .i_SrcA         (src_a),
      .i_SrcB         (src_b),
      .i_ALUResult    (alu_result),
      .i_ALUControl   (alu_control),
      .i_ShifterCarry (shifter_carry),
      .i_FlagWrite    (flag_write),
      .i_CondEx       (cond_ex),
      .i_Stall_E      (stall_e),
      .i_Flush_E      (flush_e),
      .o_Flags_NZ     (flags_nz),
      .o_Flags_CV     (flags_cv),
      .o_FlagsNext_NZ (flags_next_nz),
      .o_FlagsNext_CV (flags_next_cv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one Execute-stage instruction; qualifiers default to a valid update
   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] res, input logic [1:0] ctl,
                        input logic sc, input logic [1:0] fw, input logic cex,
                        input logic stl, input logic fls);
      src_a         = a;
      src_b         = b;
      alu_result    = res;
      alu_control   = ctl;
      shifter_carry = sc;
      flag_write    = fw;
      cond_ex       = cex;
      stall_e       = stl;
      flush_e       = fls;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      checks++;
      if (flags_nz !== 2'b00 || flags_cv !== 2'b00) begin
         errors++;
         $display("FAIL reset_regs: got nz=%b cv=%b want 00/00", flags_nz, flags_cv);
      end
      checks++;
      if (flags_next_nz !== 2'b00 || flags_next_cv !== 2'b00) begin
         errors++;
         $display("FAIL reset_next: got nz=%b cv=%b want 00/00", flags_next_nz, flags_next_cv);
      end
      rst = 1'b0;
      drive('0, '0, '0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_add_overflow();
      drive(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      checks++;
      if (flags_next_nz !== 2'b10 || flags_next_cv !== 2'b01) begin
         errors++;
         $display("FAIL add_ovf_bypass: got nz=%b cv=%b want 10/01", flags_next_nz, flags_next_cv);
      end
      checks++;
      if (flags_nz !== 2'b00 || flags_cv !== 2'b00) begin
         errors++;
         $display("FAIL add_ovf_before_edge: got nz=%b cv=%b want 00/00", flags_nz, flags_cv);
      end
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b01) begin
         errors++;
         $display("FAIL add_ovf: got nz=%b cv=%b want 10/01", flags_nz, flags_cv);
      end
   endtask

   task automatic test_sub();
      drive(32'd5, 32'd5, 32'd0, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b01 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL sub_5_5: got nz=%b cv=%b want 01/10", flags_nz, flags_cv);
      end
      drive(32'd3, 32'd5, 32'hFFFF_FFFE, 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b00) begin
         errors++;
         $display("FAIL sub_3_5: got nz=%b cv=%b want 10/00", flags_nz, flags_cv);
      end
   endtask

   task automatic test_logical();
      // 0x80000000 - 1 = 0x7FFFFFFF: no borrow and signed overflow -> CV=11
      drive(32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b00 || flags_cv !== 2'b11) begin
         errors++;
         $display("FAIL preload_cv: got nz=%b cv=%b want 00/11", flags_nz, flags_cv);
      end
      drive(32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b01 || flags_cv !== 2'b01) begin
         errors++;
         $display("FAIL orr_keep_v: got nz=%b cv=%b want 01/01", flags_nz, flags_cv);
      end
      // AND with shifter carry set: C from shifter, V still retained
      drive(32'hF000_0000, 32'h8000_0000, 32'h8000_0000, 2'b10, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b11) begin
         errors++;
         $display("FAIL and_shift_c: got nz=%b cv=%b want 10/11", flags_nz, flags_cv);
      end
      drive(32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_partial_write();
      // state entering: NZ=01 CV=01
      drive(32'd0, 32'd1, 32'hFFFF_FFFF, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b01) begin
         errors++;
         $display("FAIL write_nz_only: got nz=%b cv=%b want 10/01", flags_nz, flags_cv);
      end
      drive(32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL write_cv_only: got nz=%b cv=%b want 10/10", flags_nz, flags_cv);
      end
   endtask

   task automatic test_gating();
      // state entering: NZ=10 CV=10; SUB 5-5 would give 01/10, SUB 3-5 would give 10/00
      drive(32'd5, 32'd5, 32'd0, 2'b01, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
      checks++;
      if (flags_next_nz !== 2'b10 || flags_next_cv !== 2'b10) begin
         errors++;
         $display("FAIL condex0_bypass: got nz=%b cv=%b want 10/10", flags_next_nz, flags_next_cv);
      end
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL condex0: got nz=%b cv=%b want 10/10", flags_nz, flags_cv);
      end
      drive(32'd3, 32'd5, 32'hFFFF_FFFE, 2'b01, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (flags_nz !== 2'b10 || flags_cv !== 2'b10) begin
            errors++;
            $display("FAIL stall_cycle%0d: got nz=%b cv=%b want 10/10", i, flags_nz, flags_cv);
         end
      end
      // release stall with a different instruction: it, not the stalled one, lands
      drive(32'd5, 32'd5, 32'd0, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b01 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL stall_release: got nz=%b cv=%b want 01/10", flags_nz, flags_cv);
      end
      drive(32'd3, 32'd5, 32'hFFFF_FFFE, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
      tick();
      checks++;
      if (flags_nz !== 2'b01 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL flush: got nz=%b cv=%b want 01/10", flags_nz, flags_cv);
      end
      drive(32'd3, 32'd5, 32'hFFFF_FFFE, 2'b01, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (flags_nz !== 2'b01 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL flush_stall: got nz=%b cv=%b want 01/10", flags_nz, flags_cv);
      end
   endtask

   task automatic test_back_to_back();
      drive(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b01) begin
         errors++;
         $display("FAIL b2b_first: got nz=%b cv=%b want 10/01", flags_nz, flags_cv);
      end
      drive(32'd5, 32'd5, 32'd0, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b01 || flags_cv !== 2'b10) begin
         errors++;
         $display("FAIL b2b_second: got nz=%b cv=%b want 01/10", flags_nz, flags_cv);
      end
   endtask

   task automatic test_reset_midstream();
      // state entering: NZ=01 CV=10
      rst = 1'b1;
      drive(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      checks++;
      if (flags_next_nz !== 2'b01 || flags_next_cv !== 2'b10) begin
         errors++;
         $display("FAIL rst_next_hold: got nz=%b cv=%b want 01/10", flags_next_nz, flags_next_cv);
      end
      tick();
      checks++;
      if (flags_nz !== 2'b00 || flags_cv !== 2'b00) begin
         errors++;
         $display("FAIL rst_over_update: got nz=%b cv=%b want 00/00", flags_nz, flags_cv);
      end
      rst = 1'b0;
      drive(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (flags_next_nz !== 2'b00 || flags_next_cv !== 2'b00) begin
         errors++;
         $display("FAIL post_rst_next: got nz=%b cv=%b want 00/00", flags_next_nz, flags_next_cv);
      end
      drive(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (flags_nz !== 2'b10 || flags_cv !== 2'b01) begin
         errors++;
         $display("FAIL post_rst_update: got nz=%b cv=%b want 10/01", flags_nz, flags_cv);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive('0, '0, '0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_add_overflow();
      test_sub();
      test_logical();
      test_partial_write();
      test_gating();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
